// File: rtl/wshb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// wshb_sram_slave : Wishbone B4 responder backed by a single-port word RAM,
//                   serving classic cycles and linear bursts.
// Revision 1.0
// ---------------------------------------------------------------------------
module wshb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADR_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc,
  input  logic             stb,
  input  logic             we,
  input  logic [3:0]       sel,
  input  logic [ADR_W-1:0] adr,
  input  logic [31:0]      dat_ms,
  input  logic [2:0]       cti,
  input  logic [1:0]       bte,
  output logic [31:0]      dat_sm,
  output logic             ack,
  output logic             err
);

  localparam int             IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             PW      = ADR_W - 2;
  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]  LAST_P  = PW'(DEPTH - 1);
  localparam logic [3:0]     WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FIRST = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [31:0]     dat_q;
  logic [3:0]      cnt;
  logic            rd_valid;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_q;

  logic [IW-1:0]   ram_addr;
  logic            ram_we;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_fwd;

  logic            req;
  logic [PW-1:0]   adr_word;
  logic [PW-1:0]   ptr_nx;
  logic            adr_in;
  logic            ptr_in;
  logic            ptr_nx_in;
  logic            beat;
  logic            more;
  logic            cont;
  logic            unused_adr;

  assign req        = cyc & stb;
  assign adr_word   = adr[ADR_W-1:2];
  assign ptr_nx     = ptr + PW'(1);
  assign adr_in     = adr_word < DEPTH_P;
  assign ptr_in     = ptr < DEPTH_P;
  assign ptr_nx_in  = ptr < LAST_P;
  assign unused_adr = ^adr[1:0];

  // A beat terminates whenever the master strobes in FIRST or BURST.
  assign beat = req & ((state == S_FIRST) | (state == S_BURST));
  assign ack  = beat & ptr_in;
  assign err  = beat & ~ptr_in;
  assign more = (state == S_FIRST) ? (cti == 3'b010 && bte == 2'b00)
                                   : (cti != 3'b111);
  assign cont = ack & more;

  assign dat_sm = rd_valid ? mem_q : 32'd0;

  // Single RAM port: writes go to ptr, reads prefetch ptr+1 on a continuing beat.
  always_comb begin
    ram_addr  = ptr[IW-1:0];
    ram_we    = 1'b0;
    ram_be    = sel_q;
    ram_wdata = dat_q;
    if (state == S_IDLE && req) begin
      ram_addr = adr_word[IW-1:0];
    end
    if (ack && we_q) begin
      ram_we = 1'b1;
      if (state == S_BURST) begin
        ram_be    = sel;
        ram_wdata = dat_ms;
      end
    end else if (cont) begin
      ram_addr = ptr_nx[IW-1:0];
    end
    for (int b = 0; b < 4; b++) begin
      ram_fwd[8*b +: 8] = (ram_we && ram_be[b]) ? ram_wdata[8*b +: 8]
                                                : mem[ram_addr][8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && ram_be[b]) begin
        mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    mem_q <= ram_fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
      cnt      <= 4'd0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            ptr      <= adr_word;
            we_q     <= we;
            sel_q    <= sel;
            dat_q    <= dat_ms;
            cnt      <= 4'd0;
            rd_valid <= (WAIT_STATES == 0) && !we && adr_in;
            state    <= (WAIT_STATES > 0) ? S_WAIT : S_FIRST;
          end
        end
        S_WAIT: begin
          if (!cyc) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (cnt == WS_LAST) begin
            state    <= S_FIRST;
            cnt      <= 4'd0;
            rd_valid <= !we_q && ptr_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_FIRST, S_BURST: begin
          if (!cyc) begin
            state    <= S_IDLE;
            rd_valid <= 1'b0;
          end else if (stb) begin
            if (cont) begin
              state    <= S_BURST;
              ptr      <= ptr_nx;
              rd_valid <= !we_q && ptr_nx_in;
            end else begin
              state    <= S_IDLE;
              rd_valid <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
